// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-boundary widths and per-boundary ctrl/data layouts for the CPU datapath.
// Stage code packs/unpacks boundary fields by name through these structs.
package cpu_pipe_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_CTRL_W = 8;
  // Wide enough for main + skid entry (0..2).
  localparam int unsigned OCC_W          = 2;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbMem  = 2'd1,
    WbPc4  = 2'd2,
    WbNone = 2'd3
  } wb_sel_e;

  // IF/ID
  typedef struct packed {
    logic       pred_taken;
    logic       is_compressed;
    logic [5:0] rsvd;
  } if_id_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_data_t;

  // ID/EX
  typedef struct packed {
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    wb_sel_e    wb_sel;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       branch;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_data_t;

  // EX/MEM
  typedef struct packed {
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    wb_sel_e    wb_sel;
    logic [1:0] mem_size;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_data_t;

  // MEM/WB
  typedef struct packed {
    logic    reg_we;
    wb_sel_e wb_sel;
  } mem_wb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_data_t;

  localparam int unsigned IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int unsigned IF_ID_DATA_W  = $bits(if_id_data_t);
  localparam int unsigned ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int unsigned ID_EX_DATA_W  = $bits(id_ex_data_t);
  localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int unsigned EX_MEM_DATA_W = $bits(ex_mem_data_t);
  localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
  localparam int unsigned MEM_WB_DATA_W = $bits(mem_wb_data_t);

endpackage

// File: rtl/pipe_entry.sv
// Single valid+ctrl+data boundary register with load/clear/flush.
// Ctrl is zero whenever the entry is empty; data is held on clear, zeroed on flush/reset.
module pipe_entry
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-boundary register with optional skid entry and single-cycle flush.
// SKID=1 registers in_ready; SKID=0 is a single entry with combinational ready.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;

  logic              in_fire, out_fire, m_take;
  logic              m_load, m_clear, s_load, s_clear;
  logic [CTRL_W-1:0] m_src_ctrl;
  logic [DATA_W-1:0] m_src_data;

  logic [OCC_W-1:0]  occ_d, occ_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;

  always_comb begin
    m_take  = ~m_valid | out_fire;
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    if (SKID != 0) begin
      // S always drains into M before new input so ordering stays FIFO.
      if (m_take) begin
        m_load  = s_valid | in_fire;
        m_clear = ~(s_valid | in_fire);
        s_clear = s_valid;
      end
      s_load = in_fire & ~m_take;
    end else begin
      m_load  = in_fire;
      m_clear = out_fire & ~in_fire;
    end
    m_src_ctrl = s_valid ? s_ctrl : in_ctrl;
    m_src_data = s_valid ? s_data : in_data;
  end

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .load_i  (m_load),
    .clear_i (m_clear),
    .ctrl_i  (m_src_ctrl),
    .data_i  (m_src_data),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  if (SKID != 0) begin : g_skid
    assign in_ready = ~s_valid;

    pipe_entry #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .load_i  (s_load),
      .clear_i (s_clear),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (s_valid),
      .ctrl_o  (s_ctrl),
      .data_o  (s_data)
    );
  end else begin : g_no_skid
    assign in_ready = out_ready | ~m_valid;
    assign s_valid  = 1'b0;
    assign s_ctrl   = '0;
    assign s_data   = '0;

    logic unused_skid_ctrl;
    assign unused_skid_ctrl = s_load ^ s_clear;
  end

  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed vectors,
// expected outputs queued per instance and checked by an independent monitor.
module tb_pipe_stage_reg;

  logic        clk;
  logic [1:0]  rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_ctrl   [2];
  logic [31:0] in_data   [2];
  logic [7:0]  out_ctrl  [2];
  logic [31:0] out_data  [2];
  logic [1:0]  occ       [2];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h", name, k, act, exp);
    end
  endtask

  // Instance 0 has the skid entry, instance 1 does not.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [39:0] q[$];
    logic [39:0] exp_v;

    pipe_stage_reg #(
      .DATA_W (32),
      .CTRL_W (8),
      .SKID   ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_ctrl   (in_ctrl[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_ctrl  (out_ctrl[g]),
      .out_data  (out_data[g]),
      .occupancy (occ[g])
    );

    always @(negedge clk) begin
      if (out_valid[g] && out_ready[g]) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected dut%0d: got 0x%0h, required no output", g,
                   {out_ctrl[g], out_data[g]});
        end else begin
          exp_v = q.pop_front();
          chk("sb_output", g, 64'({out_ctrl[g], out_data[g]}), 64'(exp_v));
        end
      end
      if (!out_valid[g]) chk("bubble_ctrl", g, 64'(out_ctrl[g]), 64'd0);
    end
  end

  task automatic push(input int k, input logic [7:0] c, input logic [31:0] d);
    if (k == 0) g_mon[0].q.push_back({c, d});
    else        g_mon[1].q.push_back({c, d});
  endtask

  task automatic clear_q(input int k);
    if (k == 0) g_mon[0].q.delete();
    else        g_mon[1].q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name, input int k);
    chk({name, "_out_valid"}, k, 64'(out_valid[k]), 64'd0);
    chk({name, "_out_ctrl"},  k, 64'(out_ctrl[k]),  64'd0);
    chk({name, "_out_data"},  k, 64'(out_data[k]),  64'd0);
    chk({name, "_occupancy"}, k, 64'(occ[k]),       64'd0);
    chk({name, "_in_ready"},  k, 64'(in_ready[k]),  64'd1);
  endtask

  task automatic run_dut(input int k);
    bit skid;
    skid = (k == 0);

    // Back-to-back stream with out_ready high.
    out_ready[k] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid[k] = (i < 4);
      in_ctrl[k]  = 8'h01;
      in_data[k]  = 32'h11 * (i + 1);
      @(negedge clk);
      if (i < 4) begin
        chk("t1_in_ready", k, 64'(in_ready[k]), 64'd1);
        push(k, 8'h01, 32'h11 * (i + 1));
      end
      chk("t1_out_valid", k, 64'(out_valid[k]), (i >= 1 && i <= 4) ? 64'd1 : 64'd0);
      chk("t1_occupancy", k, 64'(occ[k]), (i >= 1 && i <= 4) ? 64'd1 : 64'd0);
      tick();
    end

    // Stall with 0xA held while 0xB is offered.
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    in_ctrl[k]   = 8'h02;
    in_data[k]   = 32'hA;
    @(negedge clk);
    chk("t2_in_ready_c0", k, 64'(in_ready[k]), 64'd1);
    push(k, 8'h02, 32'hA);
    tick();
    in_data[k] = 32'hB;
    @(negedge clk);
    chk("t2_in_ready_c1", k, 64'(in_ready[k]), skid ? 64'd1 : 64'd0);
    chk("t2_out_valid_c1", k, 64'(out_valid[k]), 64'd1);
    chk("t2_occupancy_c1", k, 64'(occ[k]), 64'd1);
    if (skid) push(k, 8'h02, 32'hB);
    tick();
    if (skid) in_valid[k] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_in_ready_stall", k, 64'(in_ready[k]), 64'd0);
      chk("t2_occupancy_stall", k, 64'(occ[k]), skid ? 64'd2 : 64'd1);
      chk("t2_hold_data", k, 64'(out_data[k]), 64'hA);
      tick();
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    chk("t2_in_ready_release", k, 64'(in_ready[k]), skid ? 64'd0 : 64'd1);
    chk("t2_occupancy_release", k, 64'(occ[k]), skid ? 64'd2 : 64'd1);
    if (!skid) push(k, 8'h02, 32'hB);
    tick();
    in_valid[k] = 1'b0;
    @(negedge clk);
    chk("t2_in_ready_drained", k, 64'(in_ready[k]), 64'd1);
    chk("t2_out_valid_b", k, 64'(out_valid[k]), 64'd1);
    chk("t2_out_data_b", k, 64'(out_data[k]), 64'hB);
    chk("t2_occupancy_b", k, 64'(occ[k]), 64'd1);
    tick();
    @(negedge clk);
    chk("t2_out_valid_end", k, 64'(out_valid[k]), 64'd0);
    chk("t2_occupancy_end", k, 64'(occ[k]), 64'd0);
    tick();

    // Flush with the boundary full and a new input presented.
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    in_ctrl[k]   = 8'h04;
    in_data[k]   = 32'h5A;
    @(negedge clk);
    push(k, 8'h04, 32'h5A);
    tick();
    in_data[k] = 32'h5B;
    @(negedge clk);
    chk("t3_in_ready_c1", k, 64'(in_ready[k]), skid ? 64'd1 : 64'd0);
    if (skid) push(k, 8'h04, 32'h5B);
    tick();
    // Without skid, flush coincides with an output fire and in_ready=1.
    in_data[k]   = 32'hC;
    flush[k]     = 1'b1;
    out_ready[k] = skid ? 1'b0 : 1'b1;
    @(negedge clk);
    chk("t3_occupancy_pre", k, 64'(occ[k]), skid ? 64'd2 : 64'd1);
    chk("t3_in_ready_flush", k, 64'(in_ready[k]), skid ? 64'd0 : 64'd1);
    tick();
    flush[k]     = 1'b0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    clear_q(k);
    @(negedge clk);
    chk_reset_vals("t3_post_flush", k);
    tick();
    @(negedge clk);
    chk("t3_out_valid_after", k, 64'(out_valid[k]), 64'd0);
    tick();

    // Reset mid-stream with one entry held.
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    in_ctrl[k]   = 8'h08;
    in_data[k]   = 32'h77;
    @(negedge clk);
    push(k, 8'h08, 32'h77);
    tick();
    in_valid[k] = 1'b0;
    rst[k]      = 1'b1;
    @(negedge clk);
    chk("t4_occupancy_pre", k, 64'(occ[k]), 64'd1);
    tick();
    rst[k]       = 1'b0;
    clear_q(k);
    in_valid[k]  = 1'b1;
    in_ctrl[k]   = 8'h10;
    in_data[k]   = 32'h99;
    out_ready[k] = 1'b1;
    @(negedge clk);
    chk_reset_vals("t4_post_rst", k);
    push(k, 8'h10, 32'h99);
    tick();
    in_valid[k] = 1'b0;
    @(negedge clk);
    chk("t4_out_valid", k, 64'(out_valid[k]), 64'd1);
    chk("t4_out_data", k, 64'(out_data[k]), 64'h99);
    tick();
    @(negedge clk);
    chk("t4_out_valid_end", k, 64'(out_valid[k]), 64'd0);
    tick();
  endtask

  initial begin
    rst       = 2'b11;
    flush     = 2'b00;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      in_ctrl[k] = '0;
      in_data[k] = '0;
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk_reset_vals("reset", k);
    tick();
    rst = 2'b00;
    for (int k = 0; k < 2; k++) run_dut(k);
    repeat (2) tick();
    chk("sb_drained", 0, 64'(g_mon[0].q.size()), 64'd0);
    chk("sb_drained", 1, 64'(g_mon[1].q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
